// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared predictor sizes, 2-bit counter encodings and counter update helper
package branch_predictor_pkg;
  localparam int BHT_BITS_DEF = 6;
  localparam int BTB_BITS_DEF = 4;
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    return taken ? (c == CTR_ST ? CTR_ST : ctr_t'(c + 2'd1)) : (c == CTR_SNT ? CTR_SNT : ctr_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped tagged target cache with combinational lookup and registered write
module branch_target_buffer
  import branch_predictor_pkg::*;
#(
  parameter int BTB_BITS = BTB_BITS_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:2] rd_pc,
  output logic        hit,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [31:2] wr_pc,
  input  logic [31:0] wr_target
);
  localparam int N  = 1 << BTB_BITS;
  localparam int TW = 30 - BTB_BITS;
  logic [N-1:0]        valid_q, valid_d;
  logic [TW-1:0]       tag_q [N];
  logic [TW-1:0]       tag_d [N];
  logic [31:0]         tgt_q [N];
  logic [31:0]         tgt_d [N];
  logic [BTB_BITS-1:0] rd_idx, wr_idx;
  assign rd_idx    = rd_pc[BTB_BITS+1:2];
  assign wr_idx    = wr_pc[BTB_BITS+1:2];
  assign hit       = valid_q[rd_idx] && tag_q[rd_idx] == rd_pc[31:BTB_BITS+2];
  assign rd_target = tgt_q[rd_idx];
  // install the resolved taken branch into its slot, replacing any alias
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_pc[31:BTB_BITS+2];
      tgt_d[wr_idx]   = wr_target;
    end
  end
  // only valid bits need reset; stale tags/targets are masked by valid
  always_ff @(posedge Clock) begin
    valid_q <= Reset ? '0 : valid_d;
    tag_q   <= tag_d;
    tgt_q   <= tgt_d;
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal BHT + BTB fetch predictor with decode-stage resolution and flush
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_BITS = BHT_BITS_DEF,
  parameter int BTB_BITS = BTB_BITS_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IF_PC,
  output logic        PredTaken,
  output logic [31:0] PredTarget,
  input  logic        ID_Valid,
  input  logic [31:0] ID_PC,
  input  logic        ID_Taken,
  input  logic [31:0] ID_Target,
  input  logic        ID_PredTaken,
  input  logic [31:0] ID_PredTarget,
  output logic        Flush,
  output logic [31:0] RedirectPC,
  output logic [15:0] MispredictCount
);
  localparam int N = 1 << BHT_BITS;
  ctr_t                bht_q [N];
  ctr_t                bht_d [N];
  logic                flush_q, flush_d;
  logic [31:0]         redirect_q, redirect_d;
  logic [15:0]         count_q, count_d;
  logic [BHT_BITS-1:0] if_idx, id_idx;
  logic                btb_hit, mispredict;
  logic [31:0]         btb_target;
  assign if_idx     = IF_PC[BHT_BITS+1:2];
  assign id_idx     = ID_PC[BHT_BITS+1:2];
  assign PredTaken  = btb_hit & bht_q[if_idx][1];
  assign PredTarget = btb_hit ? btb_target : IF_PC + 32'd4;
  assign mispredict = ID_Valid & ((ID_PredTaken != ID_Taken) | (ID_Taken & (ID_PredTarget != ID_Target)));
  assign Flush           = flush_q;
  assign RedirectPC      = redirect_q;
  assign MispredictCount = count_q;
  branch_target_buffer #(.BTB_BITS(BTB_BITS)) u_btb (
    .Clock    (Clock),
    .Reset    (Reset),
    .rd_pc    (IF_PC[31:2]),
    .hit      (btb_hit),
    .rd_target(btb_target),
    .wr_en    (ID_Valid & ID_Taken),
    .wr_pc    (ID_PC[31:2]),
    .wr_target(ID_Target)
  );
  // train the counter of the resolving branch and compute the recovery state
  always_comb begin
    bht_d = bht_q;
    if (ID_Valid) bht_d[id_idx] = ctr_next(bht_q[id_idx], ID_Taken);
    flush_d    = mispredict;
    redirect_d = mispredict ? (ID_Taken ? ID_Target : ID_PC + 32'd4) : redirect_q;
    count_d    = (mispredict && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
  end
  // reset wins over any resolution arriving in the same cycle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bht_q      <= '{default: CTR_WNT};
      flush_q    <= 1'b0;
      redirect_q <= '0;
      count_q    <= '0;
    end else begin
      bht_q      <= bht_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      count_q    <= count_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed table-driven check of prediction, training, flush and saturation
module tb_branch_predictor;
  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] IF_PC;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        ID_Valid;
  logic [31:0] ID_PC;
  logic        ID_Taken;
  logic [31:0] ID_Target;
  logic        ID_PredTaken;
  logic [31:0] ID_PredTarget;
  logic        Flush;
  logic [31:0] RedirectPC;
  logic [15:0] MispredictCount;
  int          n_cmp = 0;
  int          n_bad = 0;

  branch_predictor dut (
    .Clock(Clock), .Reset(Reset), .IF_PC(IF_PC), .PredTaken(PredTaken), .PredTarget(PredTarget),
    .ID_Valid(ID_Valid), .ID_PC(ID_PC), .ID_Taken(ID_Taken), .ID_Target(ID_Target),
    .ID_PredTaken(ID_PredTaken), .ID_PredTarget(ID_PredTarget),
    .Flush(Flush), .RedirectPC(RedirectPC), .MispredictCount(MispredictCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic [31:0] ifpc;
    logic        ef;
    logic [31:0] er;
    logic        ept;
    logic [31:0] eptgt;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt, input logic [31:0] ifpc);
    ID_Valid = v; ID_PC = pc; ID_Taken = tk; ID_Target = tgt;
    ID_PredTaken = ptk; ID_PredTarget = ptgt; IF_PC = ifpc;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h00400010, 1'b0, 32'h0, 1'b0, 32'h00400014, 16'd0};
    vecs[1]  = '{1'b1, 32'h00400010, 1'b1, 32'h00400040, 1'b0, 32'h00400014, 32'h00400010, 1'b1, 32'h00400040, 1'b1, 32'h00400040, 16'd1};
    vecs[2]  = '{1'b1, 32'h00400010, 1'b1, 32'h00400040, 1'b1, 32'h00400040, 32'h00400010, 1'b0, 32'h0, 1'b1, 32'h00400040, 16'd1};
    vecs[3]  = '{1'b1, 32'h00400010, 1'b1, 32'h00400040, 1'b1, 32'h00400040, 32'h00400010, 1'b0, 32'h0, 1'b1, 32'h00400040, 16'd1};
    vecs[4]  = '{1'b1, 32'h00400010, 1'b1, 32'h00400040, 1'b1, 32'h00400040, 32'h00400010, 1'b0, 32'h0, 1'b1, 32'h00400040, 16'd1};
    vecs[5]  = '{1'b1, 32'h00400010, 1'b0, 32'h00400040, 1'b1, 32'h00400040, 32'h00400010, 1'b1, 32'h00400014, 1'b1, 32'h00400040, 16'd2};
    vecs[6]  = '{1'b1, 32'h00400010, 1'b0, 32'h00400040, 1'b1, 32'h00400040, 32'h00400010, 1'b1, 32'h00400014, 1'b0, 32'h00400040, 16'd3};
    vecs[7]  = '{1'b1, 32'h00400010, 1'b1, 32'h00400080, 1'b1, 32'h00400040, 32'h00400010, 1'b1, 32'h00400080, 1'b1, 32'h00400080, 16'd4};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h00400410, 1'b0, 32'h0, 1'b0, 32'h00400414, 16'd4};
    vecs[9]  = '{1'b0, 32'h00400010, 1'b0, 32'h12345678, 1'b1, 32'hDEADBEEC, 32'h00400010, 1'b0, 32'h0, 1'b1, 32'h00400080, 16'd4};
    vecs[10] = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h00000100, 1'b1, 32'h00000100, 32'hFFFFFFFC, 1'b1, 32'h00000000, 1'b0, 32'h00000000, 16'd5};
    vecs[11] = '{1'b1, 32'h00400020, 1'b1, 32'h00400100, 1'b0, 32'h00400024, 32'h00400020, 1'b1, 32'h00400100, 1'b1, 32'h00400100, 16'd6};
    vecs[12] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h00400020, 1'b0, 32'h0, 1'b1, 32'h00400100, 16'd6};

    Reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h00400010);
    tick();
    tick();
    chk("reset_flush", {31'b0, Flush}, 32'd0);
    chk("reset_redirect", RedirectPC, 32'd0);
    chk("reset_count", {16'b0, MispredictCount}, 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].tk, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt, vecs[i].ifpc);
      tick();
      chk($sformatf("v%0d_flush", i), {31'b0, Flush}, {31'b0, vecs[i].ef});
      if (vecs[i].ef) chk($sformatf("v%0d_redirect", i), RedirectPC, vecs[i].er);
      chk($sformatf("v%0d_count", i), {16'b0, MispredictCount}, {16'b0, vecs[i].ec});
      chk($sformatf("v%0d_predtaken", i), {31'b0, PredTaken}, {31'b0, vecs[i].ept});
      chk($sformatf("v%0d_predtarget", i), PredTarget, vecs[i].eptgt);
    end

    drive(1'b1, 32'h00400030, 1'b1, 32'h00400200, 1'b0, 32'h00400034, 32'h00400030);
    #1;
    chk("rbw_pre_predtaken", {31'b0, PredTaken}, 32'd0);
    chk("rbw_pre_predtarget", PredTarget, 32'h00400034);
    tick();
    chk("rbw_post_predtaken", {31'b0, PredTaken}, 32'd1);
    chk("rbw_post_predtarget", PredTarget, 32'h00400200);

    Reset = 1'b1;
    drive(1'b1, 32'h00400050, 1'b1, 32'h00400300, 1'b0, 32'h00400054, 32'h00400010);
    tick();
    chk("rst_misp_flush", {31'b0, Flush}, 32'd0);
    chk("rst_misp_count", {16'b0, MispredictCount}, 32'd0);
    Reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h00400010);
    chk("post_rst_predtaken_a", {31'b0, PredTaken}, 32'd0);
    IF_PC = 32'h00400030;
    #1;
    chk("post_rst_predtaken_b", {31'b0, PredTaken}, 32'd0);
    tick();
    chk("post_rst_flush", {31'b0, Flush}, 32'd0);

    drive(1'b1, 32'h00400060, 1'b0, 32'h0, 1'b1, 32'h00400080, 32'h00400060);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_count_fffe", {16'b0, MispredictCount}, 32'h0000FFFE);
    tick();
    chk("sat_count_ffff", {16'b0, MispredictCount}, 32'h0000FFFF);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_count_hold", {16'b0, MispredictCount}, 32'h0000FFFF);
    chk("sat_flush", {31'b0, Flush}, 32'd1);
    chk("sat_redirect", RedirectPC, 32'h00400064);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BHT_BITS, default 6, meaning log2 of branch history table entries (64).
REQ-002 SHALL have parameter BTB_BITS, default 4, meaning log2 of branch target buffer entries (16).
REQ-003 SHALL have port Clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port IF_PC  input  32  fetch-stage PC to predict.
REQ-006 SHALL have port PredTaken  output  1  fetch-stage prediction: redirect fetch to PredTarget.
REQ-007 SHALL have port PredTarget  output  32  predicted target for IF_PC.
REQ-008 SHALL have port ID_Valid  input  1  a conditional branch resolves in decode this cycle.
REQ-009 SHALL have port ID_PC  input  32  PC of the resolving branch.
REQ-010 SHALL have port ID_Taken  input  1  branch comparator Result for that branch.
REQ-011 SHALL have port ID_Target  input  32  computed branch target.
REQ-012 SHALL have port ID_PredTaken  input  1  PredTaken carried down with the branch.
REQ-013 SHALL have port ID_PredTarget  input  32  PredTarget carried down with the branch.
REQ-014 SHALL have port Flush  output  1  one-cycle pulse: squash wrong-path IF/ID contents.
REQ-015 SHALL have port RedirectPC  output  32  correct next PC, valid while Flush=1.
REQ-016 SHALL have port MispredictCount  output  16  saturating count of mispredicts.

Function
REQ-017 SHALL index the BHT with PC[BHT_BITS+1:2] and the BTB with PC[BTB_BITS+1:2]; the BTB tag is PC[31:BTB_BITS+2].
REQ-018 SHALL hold one 2-bit saturating counter per BHT entry: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-019 SHALL drive PredTaken combinationally = BTB hit (valid and tag match) AND counter[1] of the IF_PC entry; PredTarget = BTB target on hit, else IF_PC+4.
REQ-020 SHALL, on a rising edge with ID_Valid=1, increment (ID_Taken=1) or decrement (ID_Taken=0) the ID_PC counter, saturating at 11 and 00.
REQ-021 SHALL, on a rising edge with ID_Valid=1 and ID_Taken=1, write the ID_PC BTB entry: valid=1, tag, target=ID_Target; ID_Taken=0 leaves the BTB unchanged.
REQ-022 SHALL define mispredict = ID_Valid AND (ID_PredTaken != ID_Taken OR (ID_Taken AND ID_PredTarget != ID_Target)).
REQ-023 SHALL register mispredict: Flush=1 exactly one cycle after the resolving cycle; RedirectPC = ID_Taken ? ID_Target : ID_PC+4, registered in the same edge.
REQ-024 SHALL deassert Flush in every cycle not following a mispredict; back-to-back mispredicts give back-to-back Flush pulses.
REQ-025 SHALL return pre-update state when IF_PC and ID_PC address the same entry in the same cycle (read-before-write).
REQ-026 SHALL increment MispredictCount on each mispredict and hold at 16'hFFFF.
REQ-027 SHALL treat ID_Valid=0 as no update; ID_* values are then ignored.
REQ-028 SHALL compute all PC+4 sums mod 2^32 (0xFFFFFFFC+4 = 0x00000000).

Reset
REQ-029 SHALL, while Reset=1, set every BHT counter to 01, clear every BTB valid bit, and set Flush=0, RedirectPC=0, MispredictCount=0.
REQ-030 SHALL give Reset priority over a simultaneous ID_Valid; a mispredict resolved in a reset cycle produces no Flush afterwards.
REQ-031 SHALL make PredTaken=0 for every IF_PC in the first cycle after reset.

Structure
REQ-032 SHALL place BHT_BITS, BTB_BITS defaults and the four counter encodings in the shared pipeline package.
REQ-033 SHALL implement the BTB (valid/tag/target arrays, lookup, write) as sub-module branch_target_buffer; the BHT and flush logic stay in branch_predictor.

Verification
REQ-034 SHALL cover: reset, IF_PC=0x00400010 -> PredTaken=0, PredTarget=0x00400014.
REQ-035 SHALL cover: ID_Valid, ID_PC=0x00400010, ID_Taken=1, ID_Target=0x00400040, ID_PredTaken=0 -> next cycle Flush=1, RedirectPC=0x00400040, MispredictCount=1; then IF_PC=0x00400010 -> PredTaken=1, PredTarget=0x00400040.
REQ-036 SHALL cover: three further taken resolutions of 0x00400010 then one not-taken -> counter 11 then 10, PredTaken stays 1; a second not-taken -> 01, PredTaken=0.
REQ-037 SHALL cover: ID_PredTaken=1, ID_PredTarget=0x00400040, ID_Taken=1, ID_Target=0x00400080 -> Flush=1, RedirectPC=0x00400080.
REQ-038 SHALL cover: alias 0x00400010 and 0x00400410 (same BTB index, different tag) -> lookup of the unwritten PC misses, PredTaken=0.
REQ-039 SHALL cover: mispredict with Reset asserted the same cycle -> Flush stays 0, MispredictCount=0; and 65536 forced mispredicts -> MispredictCount holds 0xFFFF.
